// File: rtl/puf_race_controller.sv
// ---------------------------------------------------------------------------
// puf_race_controller
//
// Sequences a ring-oscillator race arbiter to build an N_BITS-bit PUF
// response from a single challenge. For every response bit the controller
// selects an RO pair, holds the counters and arbiter in clear for SETTLE
// cycles, runs the race and captures the winning path.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-low
//   start        begin an evaluation (only honoured while idle)
//   challenge    N_BITS pairs of RO selects; pair i = {sel_b, sel_a} at
//                [i*2*SEL_W +: 2*SEL_W], sel_a in the low SEL_W bits
//   sel_a/sel_b  RO selects for path 1 / path 2
//   ro_en        RO and counter enable (high only while racing)
//   cnt_clr      counter clear (high while settling)
//   arb_rst      race-arbiter reset, active-high
//   arb_done     arbiter finished, asynchronous
//   arb_winner   arbiter result (1 = path 1 first), asynchronous
//   response     captured response, bit i from race i
//   valid        one-cycle pulse when the response is complete
//   busy         high whenever an evaluation is in progress
//   timeout_err  sticky: some bit of this run hit the race timeout
//   sel_err      sticky: some bit of this run had sel_a == sel_b
// ---------------------------------------------------------------------------
module puf_race_controller #(
    parameter int unsigned N_BITS  = 8,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N_BITS*2*SEL_W-1:0] challenge,
    output logic [SEL_W-1:0]          sel_a,
    output logic [SEL_W-1:0]          sel_b,
    output logic                      ro_en,
    output logic                      cnt_clr,
    output logic                      arb_rst,
    input  logic                      arb_done,
    input  logic                      arb_winner,
    output logic [N_BITS-1:0]         response,
    output logic                      valid,
    output logic                      busy,
    output logic                      timeout_err,
    output logic                      sel_err
);

    localparam int unsigned CH_W  = N_BITS * 2 * SEL_W;
    localparam int unsigned IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_BITS - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] TIMER_LAST  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RACE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              state, state_n;
    logic [CH_W-1:0]     chal_q, chal_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [SET_W-1:0]    settle_cnt, settle_n;
    logic [TMR_W-1:0]    timer, timer_n;
    logic [N_BITS-1:0]   resp_n;
    logic                terr_n, serr_n;
    logic [2*SEL_W-1:0]  pair_n;
    logic [SEL_W-1:0]    sel_a_n, sel_b_n;

    // Two-flop synchronisers; the FSM only ever looks at done_s/win_s.
    logic                done_m, done_s;
    logic                win_m, win_s;

    // Pair i of a packed challenge, selected without a variable-width multiply.
    function automatic logic [2*SEL_W-1:0] pair_of(input logic [CH_W-1:0]  ch,
                                                    input logic [IDX_W-1:0] i);
        logic [2*SEL_W-1:0] p;
        p = '0;
        for (int unsigned k = 0; k < N_BITS; k++) begin
            if (i == IDX_W'(k)) begin
                p = ch[k*2*SEL_W +: 2*SEL_W];
            end
        end
        return p;
    endfunction

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        chal_n   = chal_q;
        idx_n    = idx;
        settle_n = settle_cnt;
        timer_n  = timer;
        resp_n   = response;
        terr_n   = timeout_err;
        serr_n   = sel_err;
        pair_n   = {sel_b, sel_a};

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    chal_n   = challenge;
                    idx_n    = '0;
                    settle_n = '0;
                    resp_n   = '0;
                    terr_n   = 1'b0;
                    serr_n   = 1'b0;
                    pair_n   = pair_of(challenge, '0);
                    state_n  = S_CLEAR;
                end
            end

            S_CLEAR: begin
                if (settle_cnt != SETTLE_LAST) begin
                    settle_n = settle_cnt + 1'b1;
                end
                // Leave only once SETTLE cycles have elapsed AND any done left
                // over from the previous race has drained through the sync.
                if (settle_cnt == SETTLE_LAST && !done_s) begin
                    if (sel_a == sel_b) begin
                        resp_n[idx] = 1'b0;
                        serr_n      = 1'b1;
                        state_n     = S_CAPTURE;
                    end else begin
                        timer_n = '0;
                        state_n = S_RACE;
                    end
                end
            end

            S_RACE: begin
                // done is checked first so a same-cycle timeout is not an error.
                if (done_s) begin
                    resp_n[idx] = win_s;
                    state_n     = S_CAPTURE;
                end else if (timer == TIMER_LAST) begin
                    resp_n[idx] = 1'b0;
                    terr_n      = 1'b1;
                    state_n     = S_CAPTURE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            S_CAPTURE: begin
                if (idx == LAST_IDX) begin
                    state_n = S_DONE;
                end else begin
                    idx_n    = idx + 1'b1;
                    settle_n = '0;
                    pair_n   = pair_of(chal_q, idx_n);
                    state_n  = S_CLEAR;
                end
            end

            S_DONE: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        sel_a_n = pair_n[SEL_W-1:0];
        sel_b_n = pair_n[2*SEL_W-1:SEL_W];
    end

    // -----------------------------------------------------------------------
    // State, datapath and registered outputs. Control outputs are decoded
    // from the next state so they line up with the state register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            chal_q      <= '0;
            idx         <= '0;
            settle_cnt  <= '0;
            timer       <= '0;
            done_m      <= 1'b0;
            done_s      <= 1'b0;
            win_m       <= 1'b0;
            win_s       <= 1'b0;
            sel_a       <= '0;
            sel_b       <= '0;
            ro_en       <= 1'b0;
            cnt_clr     <= 1'b0;
            arb_rst     <= 1'b1;
            response    <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            state       <= state_n;
            chal_q      <= chal_n;
            idx         <= idx_n;
            settle_cnt  <= settle_n;
            timer       <= timer_n;
            done_m      <= arb_done;
            done_s      <= done_m;
            win_m       <= arb_winner;
            win_s       <= win_m;
            sel_a       <= sel_a_n;
            sel_b       <= sel_b_n;
            ro_en       <= (state_n == S_RACE);
            cnt_clr     <= (state_n == S_CLEAR);
            arb_rst     <= (state_n != S_RACE);
            response    <= resp_n;
            valid       <= (state_n == S_DONE);
            busy        <= (state_n != S_IDLE);
            timeout_err <= terr_n;
            sel_err     <= serr_n;
        end
    end

endmodule

// File: tb/tb_puf_race_controller.sv
// ---------------------------------------------------------------------------
// tb_puf_race_controller
//
// Directed bench for puf_race_controller. A behavioural arbiter reports done
// RACE_DLY cycles after the race starts with winner = (sel_a > sel_b); it can
// be told to never finish one RO pair, or to hold a stale done/winner.
// ---------------------------------------------------------------------------
module tb_puf_race_controller;

    localparam int unsigned N_BITS  = 8;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 1023;
    localparam int          RACE_DLY = 3;

    // Pair bytes are {sel_b, sel_a}, bit 0 in the low byte.
    localparam logic [63:0] CH_T1  = 64'hE0DF_CA8B_9647_5213; // -> 8'h55
    localparam logic [63:0] CH_INV = 64'h0EFD_ACB8_6974_2531; // -> 8'hAA
    localparam logic [63:0] CH_EQ  = 64'h0EFD_AAB8_6974_2531; // bit 5 a==b

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [63:0]       challenge;
    logic [SEL_W-1:0]  sel_a, sel_b;
    logic              ro_en, cnt_clr, arb_rst;
    logic              arb_done = 1'b0;
    logic              arb_winner = 1'b0;
    logic [N_BITS-1:0] response;
    logic              valid, busy, timeout_err, sel_err;

    int vectors = 0;
    int miscompares = 0;

    // Arbiter model controls
    logic force_done = 1'b0;
    logic hang_en    = 1'b0;
    int   race_cnt   = 0;

    // Per-run observations
    int bit_no;
    int clear_len [N_BITS];
    int race_len  [N_BITS];
    int valid_cnt;
    int cycles;
    int eq_race;
    logic prev_clr;

    puf_race_controller #(
        .N_BITS (N_BITS),
        .SEL_W  (SEL_W),
        .SETTLE (SETTLE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .challenge  (challenge),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .ro_en      (ro_en),
        .cnt_clr    (cnt_clr),
        .arb_rst    (arb_rst),
        .arb_done   (arb_done),
        .arb_winner (arb_winner),
        .response   (response),
        .valid      (valid),
        .busy       (busy),
        .timeout_err(timeout_err),
        .sel_err    (sel_err)
    );

    always #5 clk = ~clk;

    // Arbiter model, updated on the falling edge away from DUT sampling.
    always @(negedge clk) begin
        if (force_done) begin
            arb_done   = 1'b1;
            arb_winner = 1'b1;
        end else if (arb_rst || !ro_en) begin
            arb_done = 1'b0;
            race_cnt = 0;
        end else begin
            race_cnt++;
            if (race_cnt >= RACE_DLY && !(hang_en && sel_a == 4'h9 && sel_b == 4'h6)) begin
                arb_done   = 1'b1;
                arb_winner = (sel_a > sel_b);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_stats();
        bit_no    = -1;
        valid_cnt = 0;
        cycles    = 0;
        eq_race   = 0;
        prev_clr  = 1'b0;
        for (int i = 0; i < N_BITS; i++) begin
            clear_len[i] = 0;
            race_len[i]  = 0;
        end
    endtask

    // One falling-edge sample of the DUT outputs.
    task automatic step();
        @(negedge clk);
        cycles++;
        if (cnt_clr && !prev_clr) bit_no++;
        if (bit_no >= 0 && bit_no < N_BITS) begin
            if (cnt_clr) clear_len[bit_no]++;
            if (ro_en)   race_len[bit_no]++;
        end
        if (ro_en && sel_a == sel_b) eq_race++;
        if (valid) valid_cnt++;
        prev_clr = cnt_clr;
    endtask

    task automatic start_run(input logic [63:0] ch);
        @(posedge clk);
        #1;
        challenge = ch;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string name);
        while (valid_cnt == 0 && cycles < budget) step();
        vectors++;
        if (valid_cnt == 0) begin
            miscompares++;
            $display("FAIL %s_valid: no valid within %0d cycles (got 0 pulses, need 1)", name, budget);
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        start     = 1'b0;
        challenge = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({sel_a, sel_b, ro_en, cnt_clr, arb_rst, valid, busy, timeout_err, sel_err}
            !== {4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_ctrl: got sel=%h/%h ro=%b clr=%b arst=%b v=%b busy=%b te=%b se=%b, need 0/0 0 0 1 0 0 0 0",
                     sel_a, sel_b, ro_en, cnt_clr, arb_rst, valid, busy, timeout_err, sel_err);
        end
        vectors++;
        if (response !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_response: got %h need 00", response);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        clear_stats();
        start_run(CH_T1);
        wait_valid(3000, "basic");
        vectors++;
        if (response !== 8'h55) begin
            miscompares++;
            $display("FAIL basic_response: got %h need 55", response);
        end
        vectors++;
        if (valid_cnt !== 1) begin
            miscompares++;
            $display("FAIL basic_valid_pulses: got %0d need 1", valid_cnt);
        end
        vectors++;
        if ({timeout_err, sel_err, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL basic_flags: got te=%b se=%b busy=%b need 0 0 0", timeout_err, sel_err, busy);
        end
        for (int i = 0; i < N_BITS; i++) begin
            vectors++;
            if (clear_len[i] !== SETTLE || race_len[i] !== 5) begin
                miscompares++;
                $display("FAIL basic_timing bit %0d: clear=%0d race=%0d need clear=%0d race=5",
                         i, clear_len[i], race_len[i], SETTLE);
            end
        end
    endtask

    task automatic test_timeout();
        hang_en = 1'b1;
        clear_stats();
        start_run(CH_INV);
        wait_valid(5000, "timeout");
        hang_en = 1'b0;
        vectors++;
        if (response !== 8'hA2) begin
            miscompares++;
            $display("FAIL timeout_response: got %h need a2", response);
        end
        vectors++;
        if ({timeout_err, sel_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL timeout_flags: got te=%b se=%b need 1 0", timeout_err, sel_err);
        end
        vectors++;
        if (race_len[3] !== TIMEOUT) begin
            miscompares++;
            $display("FAIL timeout_race_len: got %0d need %0d", race_len[3], TIMEOUT);
        end
        vectors++;
        if (valid_cnt !== 1) begin
            miscompares++;
            $display("FAIL timeout_valid_pulses: got %0d need 1", valid_cnt);
        end
    endtask

    task automatic test_sel_equal();
        clear_stats();
        start_run(CH_EQ);
        wait_valid(3000, "selerr");
        vectors++;
        if (response !== 8'h8A) begin
            miscompares++;
            $display("FAIL selerr_response: got %h need 8a", response);
        end
        vectors++;
        if ({timeout_err, sel_err} !== 2'b01) begin
            miscompares++;
            $display("FAIL selerr_flags: got te=%b se=%b need 0 1", timeout_err, sel_err);
        end
        vectors++;
        if (race_len[5] !== 0 || eq_race !== 0) begin
            miscompares++;
            $display("FAIL selerr_no_race: got race5=%0d eq_cycles=%0d need 0 0", race_len[5], eq_race);
        end
    endtask

    task automatic test_abort();
        int n;
        clear_stats();
        start_run(CH_T1);
        n = 0;
        while (!(bit_no == 4 && ro_en) && n < 2000) begin
            step();
            n++;
        end
        vectors++;
        if (!(bit_no == 4 && ro_en)) begin
            miscompares++;
            $display("FAIL abort_reach_race4: got bit=%0d ro_en=%b need 4 1", bit_no, ro_en);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({sel_a, sel_b, ro_en, cnt_clr, arb_rst, valid, busy, timeout_err, sel_err, response}
            !== {4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL abort_outputs: got sel=%h/%h ro=%b clr=%b arst=%b v=%b busy=%b te=%b se=%b resp=%h",
                     sel_a, sel_b, ro_en, cnt_clr, arb_rst, valid, busy, timeout_err, sel_err, response);
        end
        repeat (2) step();
        rst = 1'b1;
        repeat (3) step();
        vectors++;
        if (valid_cnt !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_valid: got pulses=%0d busy=%b need 0 0", valid_cnt, busy);
        end
        clear_stats();
        start_run(CH_T1);
        wait_valid(3000, "abort_rerun");
        vectors++;
        if (response !== 8'h55 || {timeout_err, sel_err} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_rerun: got resp=%h te=%b se=%b need 55 0 0", response, timeout_err, sel_err);
        end
    endtask

    task automatic test_busy_ignore();
        clear_stats();
        start_run(CH_INV);
        repeat (20) step();
        @(posedge clk);
        #1;
        challenge = CH_T1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_valid(3000, "busy");
        vectors++;
        if (response !== 8'hAA) begin
            miscompares++;
            $display("FAIL busy_response: got %h need aa", response);
        end
        vectors++;
        if (valid_cnt !== 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_single_run: got pulses=%0d busy=%b need 1 0", valid_cnt, busy);
        end
    endtask

    task automatic test_stale_done();
        force_done = 1'b1;
        repeat (4) @(posedge clk);
        clear_stats();
        start_run(CH_INV);
        repeat (8) step();
        @(posedge clk);
        #1;
        force_done = 1'b0;
        wait_valid(3000, "stale");
        vectors++;
        if (clear_len[0] !== 11) begin
            miscompares++;
            $display("FAIL stale_clear_len: got %0d need 11", clear_len[0]);
        end
        vectors++;
        if (race_len[0] !== 5) begin
            miscompares++;
            $display("FAIL stale_race_len: got %0d need 5", race_len[0]);
        end
        vectors++;
        if (response !== 8'hAA || {timeout_err, sel_err} !== 2'b00) begin
            miscompares++;
            $display("FAIL stale_response: got resp=%h te=%b se=%b need aa 0 0", response, timeout_err, sel_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_sel_equal();
        test_abort();
        test_busy_ignore();
        test_stale_done();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
